hpm_counter_bank: RTL and testbench
===================================

Name: hpm_counter_bank

Overview:
- Parametrised successor to the Zihpm/Sscofpmf HPM counter block, implementing mhpmcounter3..31 and mhpmevent3..31.
- Adds configurable counter width and counter count.
- Adds multi-count events, so an event can contribute more than 1 per cycle.
- Adds a registered event-qualification stage for timing, WARL masking of mhpmevent, and defined write-versus-increment priority.
- Sits beside the CSR file: it receives CSR accesses decoded by address and raises the local counter-overflow interrupt (LCOFI) request.

Parameters:
- CSR_ADDR_WIDTH, 12, CSR address width.
- XLEN, 64, CSR data width; only 64 is legal (elaboration error otherwise).
- HPM_NUM_EVENTS, 28, number of event inputs; selector values 1..HPM_NUM_EVENTS are valid.
- HPM_NUM_COUNTERS, 29, implemented counters 3..HPM_NUM_COUNTERS+2; legal range 1..29.
- COUNTER_WIDTH, 64, implemented counter bits; legal range 32..64.
- EVENT_INC_WIDTH, 3, bits per event increment, so the maximum per-cycle increment per event is 2^EVENT_INC_WIDTH-1.

Ports:
- clk_i  in  1  core clock
- rstn_i  in  1  asynchronous, active-low reset
- addr_i  in  CSR_ADDR_WIDTH  CSR address
- we_i  in  1  write strobe for addr_i
- data_i  in  XLEN  write data
- data_o  out  XLEN  read data (combinational)
- mcountinhibit_i  in  32  bit X set inhibits counter X
- priv_lvl_i  in  2  current privilege (M/S/U encodings from riscv_pkg)
- events_i  in  HPM_NUM_EVENTS*EVENT_INC_WIDTH  per-event increment; event k occupies slice [k*EVENT_INC_WIDTH-1 -: EVENT_INC_WIDTH]
- count_ovf_int_req_o  out  1  one-cycle LCOFI request pulse
- mhpm_ovf_bits_o  out  29 ([31:3])  OF bit of each mhpmevent, for scountovf

Behaviour:
- Reset (asynchronous assert, synchronous release): all counters, mhpmevent registers and stage registers = 0; count_ovf_int_req_o = 0; mhpm_ovf_bits_o = 0; data_o = 0.
- mhpmevent WARL fields:
  - writable: bit 63 (OF), 62 (MINH), 61 (SINH), 60 (UINH), 55:0 (selector).
  - bits 59:56 read 0; writes to them are ignored.
  - any selector value is stored; out-of-range selectors count nothing.
- Stage 1 (edge N), per counter i:
  - inc_q[i] = event slice selected by mhpmevent_q[i][55:0];
  - inc_q[i] = 0 if the selector is 0 or > HPM_NUM_EVENTS, mcountinhibit_i[i] = 1, or the active privilege's INH bit is set.
  - qualification uses the mhpmevent/inhibit/priv values present in the cycle before edge N.
- Stage 2 (edge N+1): counter[i] <= (counter[i] + inc_q[i]) mod 2^COUNTER_WIDTH. Total latency from event to visible count is 2 edges.
- Overflow:
  - an overflow is a carry out of bit COUNTER_WIDTH-1 in stage 2.
  - if OF = 0: set OF and pulse count_ovf_int_req_o for exactly the cycle after that edge (registered output).
  - if OF = 1 already: the counter wraps silently with no pulse.
  - several counters overflowing on the same edge produce one pulse.
- CSR write to mhpmcounterX at edge M:
  - counter <= data_i[COUNTER_WIDTH-1:0]; this wins over the stage-2 increment landing on edge M, which is discarded.
  - inc_q computed at edge M is applied at M+1 on top of the written value.
  - a write never raises OF.
- CSR write to mhpmeventX: masked per the WARL fields. Writing OF = 1 sets it without a pulse. An OF set by hardware on the same edge as a software write takes the hardware value 1 (set dominates).
- Reads:
  - mhpmcounterX returns zero-extended counter_q.
  - mhpmeventX returns masked mhpmevent_q.
  - unimplemented indices (X ≥ HPM_NUM_COUNTERS+3) and unrelated addresses read 0; writes to them are ignored.
  - data_o = 0 whenever we_i = 1.
- Inhibit or privilege changes take effect for events sampled from the next edge; an increment already staged still lands.

Decomposition:
- hpm_pkg:
  - mhpmevent bit-position constants (OF = 63, MINH = 62, SINH = 61, UINH = 60, SEL_MSB = 55);
  - MHPMEVENT_WMASK;
  - packed struct hpm_event_cfg_t {of, minh, sinh, uinh, sel};
  - function for the counter/event index from the address.
- Sub-module hpm_counter_slice (one per counter, generate loop):
  - owns event select and qualification, inc_q stage, counter register, OF bit and overflow detect;
  - takes write-enable/data for its counter and its event register;
  - outputs counter_q, cfg_q and ovf_set.
- The top level does address decode, the read mux and the OR-reduction into the registered pulse.

Test Plan:
- Reset, then read mhpmcounter3 and mhpmevent3 -> both 0; count_ovf_int_req_o = 0.
- Write mhpmevent3 = 0xFFFF_FFFF_FFFF_FFFF -> reads back 0xF0FF_FFFF_FFFF_FFFF.
- Sel = 2 on counter 3, events_i event2 = 3 held for 4 cycles starting at cycle t -> counter reads 3, 6, 9, 12 at t+2..t+5.
- COUNTER_WIDTH = 40: write 0xFF_FFFF_FFFE, event increment of 5 -> counter = 3, OF = 1, one-cycle pulse, mhpm_ovf_bits_o[3] = 1. A second wrap produces no pulse.
- Write mhpmcounter4 = 100 on the same edge a staged increment of 2 lands, event still active -> reads 100, then 102.
- priv_lvl_i = U with UINH = 1, or mcountinhibit_i[5] = 1 -> counter 5 is frozen. Selector = 29 -> no count. Write to mhpmcounter31 with HPM_NUM_COUNTERS = 4 -> ignored, reads 0.

Source files
------------

// File: rtl/hpm_pkg.sv
// Shared definitions for the HPM counter bank: mhpmevent field layout, CSR decode
// and conversion between the XLEN view of mhpmevent and its packed configuration.
package hpm_pkg;

    localparam int unsigned MHPMEVENT_OF_BIT   = 63;
    localparam int unsigned MHPMEVENT_MINH_BIT = 62;
    localparam int unsigned MHPMEVENT_SINH_BIT = 61;
    localparam int unsigned MHPMEVENT_UINH_BIT = 60;
    localparam int unsigned MHPMEVENT_SEL_MSB  = 55;
    localparam int unsigned SEL_WIDTH          = MHPMEVENT_SEL_MSB + 1;
    localparam int unsigned CSR_IDX_WIDTH      = 5;

    localparam logic [63:0] MHPMEVENT_WMASK = 64'hF0FF_FFFF_FFFF_FFFF;

    localparam logic [1:0] PRIV_LVL_M = 2'b11;
    localparam logic [1:0] PRIV_LVL_S = 2'b01;
    localparam logic [1:0] PRIV_LVL_U = 2'b00;

    localparam logic [11:0] CSR_MHPMCOUNTER3 = 12'hB03;
    localparam logic [11:0] CSR_MHPMEVENT3   = 12'h323;

    typedef struct packed {
        logic                 of;
        logic                 minh;
        logic                 sinh;
        logic                 uinh;
        logic [SEL_WIDTH-1:0] sel;
    } hpm_event_cfg_t;

    typedef struct packed {
        logic                     is_cnt;
        logic                     is_evt;
        logic [CSR_IDX_WIDTH-1:0] idx;
    } hpm_csr_dec_t;

    // Classify an address as mhpmcounterX / mhpmeventX (X >= 3) and extract X.
    function automatic hpm_csr_dec_t hpm_decode(input logic [11:0] addr);
        hpm_csr_dec_t d;
        d     = '0;
        d.idx = addr[4:0];
        if (addr[4:0] >= 5'd3) begin
            d.is_cnt = (addr[11:5] == CSR_MHPMCOUNTER3[11:5]);
            d.is_evt = (addr[11:5] == CSR_MHPMEVENT3[11:5]);
        end
        return d;
    endfunction

    function automatic hpm_event_cfg_t hpm_cfg_from_xlen(input logic [63:0] d);
        logic [63:0] m;
        m = d & MHPMEVENT_WMASK;
        return hpm_event_cfg_t'({m[MHPMEVENT_OF_BIT], m[MHPMEVENT_MINH_BIT],
                                 m[MHPMEVENT_SINH_BIT], m[MHPMEVENT_UINH_BIT],
                                 m[MHPMEVENT_SEL_MSB:0]});
    endfunction

    function automatic logic [63:0] hpm_cfg_to_xlen(input hpm_event_cfg_t c);
        return {c.of, c.minh, c.sinh, c.uinh, 4'b0000, c.sel};
    endfunction

endpackage

// File: rtl/hpm_counter_slice.sv
// One HPM counter: event select/qualification stage, counter register, OF bit
// and overflow detection. A CSR write to the counter discards the landing increment.
module hpm_counter_slice
    import hpm_pkg::*;
#(
    parameter int unsigned COUNTER_WIDTH   = 64,
    parameter int unsigned EVENT_INC_WIDTH = 3,
    parameter int unsigned HPM_NUM_EVENTS  = 28
) (
    input  logic                                      clk_i,
    input  logic                                      rstn_i,
    input  logic                                      inhibit,
    input  logic [1:0]                                priv_lvl,
    input  logic [HPM_NUM_EVENTS*EVENT_INC_WIDTH-1:0] events,
    input  logic                                      cnt_we,
    input  logic                                      evt_we,
    input  logic [63:0]                               wdata,
    output logic [COUNTER_WIDTH-1:0]                  counter_q,
    output hpm_event_cfg_t                            cfg_q,
    output logic                                      ovf_set_c
);

    localparam int unsigned SUM_WIDTH = COUNTER_WIDTH + 1;

    logic [EVENT_INC_WIDTH-1:0] sel_inc_c;
    logic [EVENT_INC_WIDTH-1:0] inc_q;
    logic                       priv_inh_c;
    logic [SUM_WIDTH-1:0]       sum_c;
    logic                       ovf_c;
    logic                       unused_wdata;

    assign unused_wdata = ^wdata;

    // Out-of-range or zero selectors match no event and contribute nothing.
    always_comb begin
        sel_inc_c = '0;
        for (int unsigned k = 1; k <= HPM_NUM_EVENTS; k++) begin
            if (cfg_q.sel == SEL_WIDTH'(k)) begin
                sel_inc_c = events[(k-1)*EVENT_INC_WIDTH +: EVENT_INC_WIDTH];
            end
        end
    end

    always_comb begin
        priv_inh_c = 1'b0;
        case (priv_lvl)
            PRIV_LVL_M: priv_inh_c = cfg_q.minh;
            PRIV_LVL_S: priv_inh_c = cfg_q.sinh;
            PRIV_LVL_U: priv_inh_c = cfg_q.uinh;
            default:    priv_inh_c = 1'b0;
        endcase
    end

    assign sum_c     = {1'b0, counter_q} + SUM_WIDTH'(inc_q);
    assign ovf_c     = sum_c[COUNTER_WIDTH] & ~cnt_we;
    assign ovf_set_c = ovf_c & ~cfg_q.of;

    always_ff @(posedge clk_i or negedge rstn_i) begin
        if (!rstn_i) begin
            inc_q     <= '0;
            counter_q <= '0;
            cfg_q     <= '0;
        end else begin
            inc_q     <= (inhibit || priv_inh_c) ? '0 : sel_inc_c;
            counter_q <= cnt_we ? wdata[COUNTER_WIDTH-1:0] : sum_c[COUNTER_WIDTH-1:0];
            if (evt_we) begin
                cfg_q <= hpm_cfg_from_xlen(wdata);
            end
            // Hardware overflow dominates a same-edge software write of OF.
            if (ovf_c) begin
                cfg_q.of <= 1'b1;
            end
        end
    end

endmodule

// File: rtl/hpm_counter_bank.sv
// HPM counter bank (mhpmcounter3.., mhpmevent3..): CSR decode, read mux and the
// registered local counter-overflow interrupt request.
module hpm_counter_bank
    import hpm_pkg::*;
#(
    parameter int unsigned CSR_ADDR_WIDTH   = 12,
    parameter int unsigned XLEN             = 64,
    parameter int unsigned HPM_NUM_EVENTS   = 28,
    parameter int unsigned HPM_NUM_COUNTERS = 29,
    parameter int unsigned COUNTER_WIDTH    = 64,
    parameter int unsigned EVENT_INC_WIDTH  = 3
) (
    input  logic                                      clk_i,
    input  logic                                      rstn_i,
    input  logic [CSR_ADDR_WIDTH-1:0]                 addr_i,
    input  logic                                      we_i,
    input  logic [XLEN-1:0]                           data_i,
    output logic [XLEN-1:0]                           data_o,
    input  logic [31:0]                               mcountinhibit_i,
    input  logic [1:0]                                priv_lvl_i,
    input  logic [HPM_NUM_EVENTS*EVENT_INC_WIDTH-1:0] events_i,
    output logic                                      count_ovf_int_req_o,
    output logic [31:3]                               mhpm_ovf_bits_o
);

    localparam int unsigned NC = HPM_NUM_COUNTERS;

    if (XLEN != 64) begin : g_xlen_err
        $error("hpm_counter_bank: XLEN must be 64");
    end
    if (NC < 1 || NC > 29) begin : g_nc_err
        $error("hpm_counter_bank: HPM_NUM_COUNTERS must be 1..29");
    end
    if (COUNTER_WIDTH < 32 || COUNTER_WIDTH > 64) begin : g_cw_err
        $error("hpm_counter_bank: COUNTER_WIDTH must be 32..64");
    end

    hpm_csr_dec_t               dec_c;
    logic [COUNTER_WIDTH-1:0]   counter_q [NC];
    hpm_event_cfg_t             cfg_q [NC];
    logic [NC-1:0]              ovf_set_c;
    logic                       unused_inputs;

    assign dec_c         = hpm_decode(12'(addr_i));
    assign unused_inputs = ^{addr_i, mcountinhibit_i};

    for (genvar i = 0; i < NC; i++) begin : g_slice
        localparam int unsigned IDX = i + 3;

        hpm_counter_slice #(
            .COUNTER_WIDTH   (COUNTER_WIDTH),
            .EVENT_INC_WIDTH (EVENT_INC_WIDTH),
            .HPM_NUM_EVENTS  (HPM_NUM_EVENTS)
        ) u_slice (
            .clk_i     (clk_i),
            .rstn_i    (rstn_i),
            .inhibit   (mcountinhibit_i[IDX]),
            .priv_lvl  (priv_lvl_i),
            .events    (events_i),
            .cnt_we    (we_i && dec_c.is_cnt && (dec_c.idx == CSR_IDX_WIDTH'(IDX))),
            .evt_we    (we_i && dec_c.is_evt && (dec_c.idx == CSR_IDX_WIDTH'(IDX))),
            .wdata     (64'(data_i)),
            .counter_q (counter_q[i]),
            .cfg_q     (cfg_q[i]),
            .ovf_set_c (ovf_set_c[i])
        );
    end

    // Unimplemented indices, unrelated addresses and write cycles read as zero.
    always_comb begin
        data_o = '0;
        for (int unsigned i = 0; i < NC; i++) begin
            if (!we_i && dec_c.idx == CSR_IDX_WIDTH'(i + 3)) begin
                if (dec_c.is_cnt) data_o = XLEN'(counter_q[i]);
                if (dec_c.is_evt) data_o = XLEN'(hpm_cfg_to_xlen(cfg_q[i]));
            end
        end
    end

    always_comb begin
        mhpm_ovf_bits_o = '0;
        for (int unsigned i = 0; i < NC; i++) begin
            mhpm_ovf_bits_o[i + 3] = cfg_q[i].of;
        end
    end

    always_ff @(posedge clk_i or negedge rstn_i) begin
        if (!rstn_i) begin
            count_ovf_int_req_o <= 1'b0;
        end else begin
            count_ovf_int_req_o <= |ovf_set_c;
        end
    end

endmodule

// File: tb/tb_hpm_counter_bank.sv
// Scoreboard bench for hpm_counter_bank (40-bit counters, 4 counters: 3..6).
module tb_hpm_counter_bank;
    import hpm_pkg::*;

    localparam int unsigned CW = 40;
    localparam int unsigned NE = 28;
    localparam int unsigned NC = 4;
    localparam int unsigned IW = 3;

    logic              clk_i = 1'b0;
    logic              rstn_i;
    logic [11:0]       addr_i;
    logic              we_i;
    logic [63:0]       data_i;
    logic [63:0]       data_o;
    logic [31:0]       mcountinhibit_i;
    logic [1:0]        priv_lvl_i;
    logic [NE*IW-1:0]  events_i;
    logic              count_ovf_int_req_o;
    logic [31:3]       mhpm_ovf_bits_o;

    int          n_vec = 0;
    int          n_err = 0;
    logic [63:0] sb_q [$];

    hpm_counter_bank #(
        .CSR_ADDR_WIDTH   (12),
        .XLEN             (64),
        .HPM_NUM_EVENTS   (NE),
        .HPM_NUM_COUNTERS (NC),
        .COUNTER_WIDTH    (CW),
        .EVENT_INC_WIDTH  (IW)
    ) dut (
        .clk_i               (clk_i),
        .rstn_i              (rstn_i),
        .addr_i              (addr_i),
        .we_i                (we_i),
        .data_i              (data_i),
        .data_o              (data_o),
        .mcountinhibit_i     (mcountinhibit_i),
        .priv_lvl_i          (priv_lvl_i),
        .events_i            (events_i),
        .count_ovf_int_req_o (count_ovf_int_req_o),
        .mhpm_ovf_bits_o     (mhpm_ovf_bits_o)
    );

    always #5 clk_i = ~clk_i;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_vec++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk_i);
        #1;
    endtask

    task automatic expect_rd(input logic [63:0] exp);
        sb_q.push_back(exp);
    endtask

    task automatic rd(input string tag, input logic [11:0] addr);
        logic [63:0] e;
        addr_i = addr;
        we_i   = 1'b0;
        #1;
        e = (sb_q.size() != 0) ? sb_q.pop_front() : ~data_o;
        check(tag, data_o, e);
    endtask

    task automatic wr(input logic [11:0] addr, input logic [63:0] d);
        addr_i = addr;
        data_i = d;
        we_i   = 1'b1;
        #1;
        check("rd_zero_during_we", data_o, 64'h0);
        @(posedge clk_i);
        #1;
        we_i = 1'b0;
    endtask

    task automatic set_ev(input int unsigned k, input int unsigned v);
        events_i[(k-1)*IW +: IW] = IW'(v);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: run exceeded time limit");
        $fatal(1, "watchdog");
    end

    initial begin
        rstn_i          = 1'b0;
        addr_i          = '0;
        we_i            = 1'b0;
        data_i          = '0;
        mcountinhibit_i = '0;
        priv_lvl_i      = PRIV_LVL_M;
        events_i        = '0;
        repeat (2) @(posedge clk_i);
        @(negedge clk_i);
        rstn_i = 1'b1;
        tick();

        // Reset state
        expect_rd(64'h0); rd("rst_cnt3", 12'hB03);
        expect_rd(64'h0); rd("rst_evt3", 12'h323);
        check("rst_pulse", 64'(count_ovf_int_req_o), 64'h0);
        check("rst_ovf_bits", 64'(mhpm_ovf_bits_o), 64'h0);

        // WARL masking of mhpmevent; software OF set gives no pulse
        wr(12'h323, 64'hFFFF_FFFF_FFFF_FFFF);
        expect_rd(64'hF0FF_FFFF_FFFF_FFFF); rd("warl_evt3", 12'h323);
        check("warl_ovf_bit3", 64'(mhpm_ovf_bits_o), 64'h1);
        tick();
        check("warl_no_pulse", 64'(count_ovf_int_req_o), 64'h0);

        // Multi-count event: sel=2, event2=3 held 4 cycles
        wr(12'h323, 64'h2);
        set_ev(2, 3);
        expect_rd(64'd3); expect_rd(64'd6); expect_rd(64'd9); expect_rd(64'd12); expect_rd(64'd12);
        tick();
        tick(); rd("cnt3_t2", 12'hB03);
        tick(); rd("cnt3_t3", 12'hB03);
        tick(); rd("cnt3_t4", 12'hB03);
        set_ev(2, 0);
        tick(); rd("cnt3_t5", 12'hB03);
        tick(); rd("cnt3_hold", 12'hB03);

        // First wrap: OF set, single pulse
        wr(12'hB03, 64'hFF_FFFF_FFFE);
        set_ev(2, 5);
        tick();
        set_ev(2, 0);
        check("ovf1_pre_pulse", 64'(count_ovf_int_req_o), 64'h0);
        tick();
        expect_rd(64'd3); rd("ovf1_cnt3", 12'hB03);
        check("ovf1_pulse", 64'(count_ovf_int_req_o), 64'h1);
        check("ovf1_bits", 64'(mhpm_ovf_bits_o), 64'h1);
        expect_rd(64'h8000_0000_0000_0002); rd("ovf1_evt3", 12'h323);
        tick();
        check("ovf1_pulse_end", 64'(count_ovf_int_req_o), 64'h0);

        // Second wrap with OF already set: silent
        wr(12'hB03, 64'hFF_FFFF_FFFE);
        set_ev(2, 5);
        tick();
        set_ev(2, 0);
        tick();
        expect_rd(64'd3); rd("ovf2_cnt3", 12'hB03);
        check("ovf2_no_pulse", 64'(count_ovf_int_req_o), 64'h0);
        tick();
        check("ovf2_no_pulse_next", 64'(count_ovf_int_req_o), 64'h0);

        // CSR write beats the landing increment; next increment stacks on it
        wr(12'h324, 64'h1);
        set_ev(1, 2);
        tick();
        tick();
        expect_rd(64'd2); rd("wvi_before", 12'hB04);
        expect_rd(64'd100); expect_rd(64'd102);
        wr(12'hB04, 64'd100);
        rd("wvi_written", 12'hB04);
        tick(); rd("wvi_after", 12'hB04);
        set_ev(1, 0);

        // Privilege and mcountinhibit gating on counter 5
        priv_lvl_i = PRIV_LVL_U;
        wr(12'h325, 64'h1000_0000_0000_0001);
        set_ev(1, 7);
        repeat (3) tick();
        expect_rd(64'd0); rd("uinh_frozen", 12'hB05);
        priv_lvl_i = PRIV_LVL_M;
        tick();
        tick();
        expect_rd(64'd7); rd("priv_m_count", 12'hB05);
        mcountinhibit_i[5] = 1'b1;
        tick();
        expect_rd(64'd14); rd("inh_staged_lands", 12'hB05);
        tick();
        tick();
        expect_rd(64'd14); rd("inh_frozen", 12'hB05);
        mcountinhibit_i = '0;
        set_ev(1, 0);

        // Selector boundary on counter 6: 29 counts nothing, 28 counts
        events_i = '1;
        wr(12'h326, 64'd29);
        repeat (3) tick();
        expect_rd(64'd0); rd("sel29_none", 12'hB06);
        wr(12'h326, 64'd28);
        repeat (3) tick();
        expect_rd(64'd14); rd("sel28_count", 12'hB06);
        events_i = '0;

        // Unimplemented and unrelated addresses
        wr(12'hB1F, 64'd123);
        expect_rd(64'h0); rd("unimp_cnt31", 12'hB1F);
        wr(12'h33F, 64'hFFFF_FFFF_FFFF_FFFF);
        expect_rd(64'h0); rd("unimp_evt31", 12'h33F);
        wr(12'hB07, 64'd55);
        expect_rd(64'h0); rd("unimp_cnt7", 12'hB07);
        expect_rd(64'h0); rd("unrelated_addr", 12'h000);
        expect_rd(64'h8000_0000_0000_0002); rd("evt3_untouched", 12'h323);

        check("sb_drain", 64'(sb_q.size()), 64'h0);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
